xcvr_pattern_checker: RTL and testbench
=======================================

XCVR_PATTERN_CHECKER -- requirements
Module: xcvr_pattern_checker

Interface
REQ-001 SHALL have parameters: G_DATA_WID, default 32, RX word width (multiple of 8, 16..64); G_SYNC_CNT, default 4, consecutive commas needed to arm; G_LOSS_CNT, default 8, consecutive bad words before lock loss; G_PCS_ERR_THR, default 3, code-error threshold; G_PCS_RST_LEN, default 4, lane-reset pulse length in cycles.
REQ-002 SHALL have ports (name direction width meaning): clk_i in 1 RX parallel clock; ARST_N in 1 async active-low reset; rx_val_i in 1 RX word valid; data_in_i in G_DATA_WID RX data; rx_k_i in G_DATA_WID/8 K-char flags; disp_err_i in G_DATA_WID/8 disparity errors; lcv_err_i in G_DATA_WID/8 code violations; rx_ready_i in 1 PCS ready; reset_en_i in 1 lane-reset enable; mode_i in 1 (0 increment, 1 decrement); start_i in 1 snapshot enable (async); clear_i in 1 counter clear (async); lane_arst_n_o out 1 PCS lane reset, active-low; lock_o out 1 pattern locked; error_o out 1 word mismatch last cycle; word_err_cnt_o out 32 snapshot mismatched words; bit_err_cnt_o out 32 snapshot mismatched bits; state_o out 3 FSM state.

Function
REQ-003 SHALL ignore every data-path input on cycles with rx_val_i=0 (FSM, expected value, counters hold).
REQ-004 SHALL define a comma word as rx_k_i = 1 in bit 0 only, and data_in_i = 0xBC in byte 0 with all other bytes zero.
REQ-005 SHALL implement FSM HUNT(0)->SYNC(1)->SEED(2)->LOCKED(3); HUNT->SYNC on a comma; SYNC counts commas and returns to HUNT on any non-comma before G_SYNC_CNT total; the G_SYNC_CNT-th comma ->SEED.
REQ-006 SHALL in SEED stay while commas arrive, return to HUNT on any other K-flagged word, and on the first word with rx_k_i=0 load expected = data_in_i +1 (mode 0) or -1 (mode 1), modulo 2^G_DATA_WID, then go to LOCKED; the seed word is never counted as an error.
REQ-007 SHALL in LOCKED compare each valid word with expected, then advance expected by ±1 with wrap-around (all-ones+1 = 0, 0-1 = all-ones).
REQ-008 SHALL on a mismatch assert error_o for one cycle, increment the word error counter by 1, increment the bit error counter by popcount(data XOR expected), and increment the consecutive-bad counter.
REQ-009 SHALL clear the consecutive-bad counter on any match; on reaching G_LOSS_CNT go to HUNT the next cycle.
REQ-010 SHALL drive lock_o=1 exactly while the state is LOCKED; total latency from data_in_i to error_o is one clock.
REQ-011 SHALL saturate both error counters at 0xFFFFFFFF; the bit counter SHALL saturate rather than wrap when an addition would overflow.
REQ-012 SHALL synchronise start_i and clear_i through two flops; a synchronised clear rising edge zeroes both counters and takes priority over a same-cycle increment.
REQ-013 SHALL copy the internal counters to word_err_cnt_o/bit_err_cnt_o every cycle the synchronised start is 1, and hold them otherwise.
REQ-014 SHALL count, in an 8-bit code-error counter, cycles with rx_ready_i=1 and any disp_err_i/lcv_err_i bit set; the counter clears when rx_ready_i=0, reset_en_i=0, lane reset is active, or a free-running 8-bit window counter wraps from 0xFF.
REQ-015 SHALL, when the code-error counter exceeds G_PCS_ERR_THR, drive lane_arst_n_o low for exactly G_PCS_RST_LEN cycles starting the next cycle, force the FSM to HUNT, and not retrigger until the pulse ends.
REQ-016 SHALL let a mode_i change take effect only at the next SEED load.

Reset
REQ-017 SHALL on ARST_N=0 asynchronously set state HUNT, lock_o=0, error_o=0, all counters and snapshots to 0, expected to 0, synchronisers to 0, and lane_arst_n_o=1; release is synchronous to clk_i.
REQ-018 SHALL, after ARST_N asserts mid-lock, restart from HUNT with no error counted for the interrupted word.

Structure
REQ-019 SHALL place the FSM state encoding, mode constants and the comma byte value 0xBC in a shared package, xcvr_chk_pkg.
REQ-020 SHALL implement the code-error counter, window counter and lane-reset pulse in one sub-module, xcvr_pcs_err_mon.

Verification
REQ-021 SHALL cover: 4 commas, then 0x00000010, 0x11, 0x12 in mode 0 -> LOCKED after the seed word, lock_o=1, no errors.
REQ-022 SHALL cover: locked, then 0x00000014 received when 0x00000013 is expected -> error_o pulse, word count +1, bit count +3, lock held.
REQ-023 SHALL cover: locked, then 8 consecutive bad words -> HUNT on the cycle after the 8th, lock_o=0, word count = 8.
REQ-024 SHALL cover: seed 0xFFFFFFFE in mode 0 -> 0xFFFFFFFF then 0x00000000 accepted, no errors; and mode 1 seed 0x00000001 -> 0x0, then 0xFFFFFFFF accepted.
REQ-025 SHALL cover: 4 code-error cycles within one window with rx_ready_i=1 and reset_en_i=1 -> lane_arst_n_o low for exactly 4 cycles and FSM to HUNT; with reset_en_i=0 -> no pulse.
REQ-026 SHALL cover: clear_i pulsed on the same cycle as a mismatch -> counters read 0 after snapshot; start_i held -> snapshot tracks the counters 2 cycles later.

Source files
------------

// File: rtl/xcvr_chk_pkg.sv
// Shared definitions for the transceiver pattern checker: FSM encoding,
// counting-mode constants, comma byte and a population-count helper.
package xcvr_chk_pkg;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_SEED   = 3'd2,
    ST_LOCKED = 3'd3
  } chk_state_t;

  localparam logic       C_MODE_INC   = 1'b0;
  localparam logic       C_MODE_DEC   = 1'b1;
  localparam logic [7:0] C_COMMA_BYTE = 8'hBC;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/xcvr_pcs_err_mon.sv
// PCS code-error monitor: counts disparity/code-violation cycles inside a
// free-running 256-cycle window and fires a fixed-length lane reset pulse.
module xcvr_pcs_err_mon
  import xcvr_chk_pkg::*;
#(
  parameter int G_ERR_WID     = 4,
  parameter int G_PCS_ERR_THR = 3,
  parameter int G_PCS_RST_LEN = 4
) (
  input  logic                 clk_i,
  input  logic                 ARST_N,
  input  logic                 rx_ready_i,
  input  logic                 reset_en_i,
  input  logic [G_ERR_WID-1:0] disp_err_i,
  input  logic [G_ERR_WID-1:0] lcv_err_i,
  output logic                 lane_arst_n_o,
  output logic                 lane_rst_act_o
);

  localparam logic [7:0] C_THR = 8'(G_PCS_ERR_THR);
  localparam logic [7:0] C_LEN = 8'(G_PCS_RST_LEN);

  logic [7:0] win_r;
  logic [7:0] err_cnt_r;
  logic [7:0] pulse_cnt_r;
  logic       lane_n_r;
  logic       err_s;
  logic       clr_s;

  assign err_s          = (|disp_err_i) | (|lcv_err_i);
  assign clr_s          = ~rx_ready_i | ~reset_en_i | ~lane_n_r | (win_r == 8'hFF);
  assign lane_arst_n_o  = lane_n_r;
  assign lane_rst_act_o = ~lane_n_r;

  // Window counter, code-error counter and lane reset pulse generator
  always_ff @(posedge clk_i or negedge ARST_N) begin
    if (!ARST_N) begin
      win_r       <= 8'd0;
      err_cnt_r   <= 8'd0;
      pulse_cnt_r <= 8'd0;
      lane_n_r    <= 1'b1;
    end else begin
      win_r <= win_r + 8'd1;
      if (clr_s) begin
        err_cnt_r <= 8'd0;
      end else if (err_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
      if (!lane_n_r) begin
        if (pulse_cnt_r <= 8'd1) begin
          lane_n_r    <= 1'b1;
          pulse_cnt_r <= 8'd0;
        end else begin
          pulse_cnt_r <= pulse_cnt_r - 8'd1;
        end
      end else if (err_cnt_r > C_THR) begin
        lane_n_r    <= 1'b0;
        pulse_cnt_r <= C_LEN;
      end
    end
  end

endmodule

// File: rtl/xcvr_pattern_checker.sv
// Incrementing/decrementing PRBS-style pattern checker: comma alignment,
// seed load, word/bit error counting with snapshot, and PCS lane-reset control.
module xcvr_pattern_checker
  import xcvr_chk_pkg::*;
#(
  parameter int G_DATA_WID    = 32,
  parameter int G_SYNC_CNT    = 4,
  parameter int G_LOSS_CNT    = 8,
  parameter int G_PCS_ERR_THR = 3,
  parameter int G_PCS_RST_LEN = 4
) (
  input  logic                    clk_i,
  input  logic                    ARST_N,
  input  logic                    rx_val_i,
  input  logic [G_DATA_WID-1:0]   data_in_i,
  input  logic [G_DATA_WID/8-1:0] rx_k_i,
  input  logic [G_DATA_WID/8-1:0] disp_err_i,
  input  logic [G_DATA_WID/8-1:0] lcv_err_i,
  input  logic                    rx_ready_i,
  input  logic                    reset_en_i,
  input  logic                    mode_i,
  input  logic                    start_i,
  input  logic                    clear_i,
  output logic                    lane_arst_n_o,
  output logic                    lock_o,
  output logic                    error_o,
  output logic [31:0]             word_err_cnt_o,
  output logic [31:0]             bit_err_cnt_o,
  output logic [2:0]              state_o
);

  localparam int                    KW          = G_DATA_WID / 8;
  localparam logic [7:0]            C_SYNC_LAST = 8'(G_SYNC_CNT - 1);
  localparam logic [7:0]            C_LOSS_LAST = 8'(G_LOSS_CNT - 1);
  localparam logic [G_DATA_WID-1:0] C_ONE       = {{(G_DATA_WID-1){1'b0}}, 1'b1};
  localparam logic [G_DATA_WID-1:0] C_COMMA     = {{(G_DATA_WID-8){1'b0}}, C_COMMA_BYTE};
  localparam logic [KW-1:0]         C_COMMA_K   = {{(KW-1){1'b0}}, 1'b1};

  chk_state_t            state_r;
  logic                  lock_r, error_r, mode_r;
  logic [G_DATA_WID-1:0] exp_r;
  logic [7:0]            sync_cnt_r, bad_cnt_r;
  logic [31:0]           word_cnt_r, bit_cnt_r, word_snap_r, bit_snap_r;
  logic                  start_meta_r, start_sync_r;
  logic                  clear_meta_r, clear_sync_r, clear_dly_r;
  logic                  lane_act_s, is_comma_s, mismatch_s, count_en_s, clear_pulse_s;
  logic [G_DATA_WID-1:0] diff_s;
  logic [32:0]           bit_sum_s;

  xcvr_pcs_err_mon #(
    .G_ERR_WID     (KW),
    .G_PCS_ERR_THR (G_PCS_ERR_THR),
    .G_PCS_RST_LEN (G_PCS_RST_LEN)
  ) u_pcs_err_mon (
    .clk_i          (clk_i),
    .ARST_N         (ARST_N),
    .rx_ready_i     (rx_ready_i),
    .reset_en_i     (reset_en_i),
    .disp_err_i     (disp_err_i),
    .lcv_err_i      (lcv_err_i),
    .lane_arst_n_o  (lane_arst_n_o),
    .lane_rst_act_o (lane_act_s)
  );

  assign is_comma_s    = (rx_k_i == C_COMMA_K) && (data_in_i == C_COMMA);
  assign diff_s        = data_in_i ^ exp_r;
  assign mismatch_s    = |diff_s;
  assign bit_sum_s     = {1'b0, bit_cnt_r} + {26'd0, popcount64(64'(diff_s))};
  assign count_en_s    = rx_val_i && !lane_act_s && (state_r == ST_LOCKED) && mismatch_s;
  assign clear_pulse_s = clear_sync_r & ~clear_dly_r;

  assign lock_o         = lock_r;
  assign error_o        = error_r;
  assign state_o        = state_r;
  assign word_err_cnt_o = word_snap_r;
  assign bit_err_cnt_o  = bit_snap_r;

  // Alignment FSM with expected-value tracking; a lane reset forces re-hunt
  always_ff @(posedge clk_i or negedge ARST_N) begin
    if (!ARST_N) begin
      state_r <= ST_HUNT; lock_r <= 1'b0; error_r <= 1'b0; mode_r <= C_MODE_INC;
      exp_r <= '0; sync_cnt_r <= 8'd0; bad_cnt_r <= 8'd0;
    end else if (lane_act_s) begin
      state_r <= ST_HUNT; lock_r <= 1'b0; error_r <= 1'b0;
      sync_cnt_r <= 8'd0; bad_cnt_r <= 8'd0;
    end else if (!rx_val_i) begin
      error_r <= 1'b0;
    end else begin
      error_r <= 1'b0;
      case (state_r)
        ST_HUNT: begin
          if (is_comma_s) begin
            state_r <= ST_SYNC; sync_cnt_r <= 8'd1;
          end
        end
        ST_SYNC: begin
          if (!is_comma_s) begin
            state_r <= ST_HUNT; sync_cnt_r <= 8'd0;
          end else if (sync_cnt_r >= C_SYNC_LAST) begin
            state_r <= ST_SEED;
          end else begin
            sync_cnt_r <= sync_cnt_r + 8'd1;
          end
        end
        ST_SEED: begin
          if (is_comma_s) begin
            state_r <= ST_SEED;
          end else if (|rx_k_i) begin
            state_r <= ST_HUNT; sync_cnt_r <= 8'd0;
          end else begin
            exp_r     <= (mode_i == C_MODE_DEC) ? data_in_i - C_ONE : data_in_i + C_ONE;
            mode_r    <= mode_i;
            state_r   <= ST_LOCKED;
            lock_r    <= 1'b1;
            bad_cnt_r <= 8'd0;
          end
        end
        ST_LOCKED: begin
          exp_r <= (mode_r == C_MODE_DEC) ? exp_r - C_ONE : exp_r + C_ONE;
          if (!mismatch_s) begin
            bad_cnt_r <= 8'd0;
          end else begin
            error_r <= 1'b1;
            if (bad_cnt_r >= C_LOSS_LAST) begin
              state_r <= ST_HUNT; lock_r <= 1'b0; bad_cnt_r <= 8'd0; sync_cnt_r <= 8'd0;
            end else begin
              bad_cnt_r <= bad_cnt_r + 8'd1;
            end
          end
        end
        default: begin
          state_r <= ST_HUNT; lock_r <= 1'b0;
        end
      endcase
    end
  end

  // Two-flop synchronisers for the asynchronous start/clear controls
  always_ff @(posedge clk_i or negedge ARST_N) begin
    if (!ARST_N) begin
      start_meta_r <= 1'b0; start_sync_r <= 1'b0;
      clear_meta_r <= 1'b0; clear_sync_r <= 1'b0; clear_dly_r <= 1'b0;
    end else begin
      start_meta_r <= start_i;  start_sync_r <= start_meta_r;
      clear_meta_r <= clear_i;  clear_sync_r <= clear_meta_r;
      clear_dly_r  <= clear_sync_r;
    end
  end

  // Saturating error counters; a clear edge beats a same-cycle increment
  always_ff @(posedge clk_i or negedge ARST_N) begin
    if (!ARST_N) begin
      word_cnt_r <= 32'd0; bit_cnt_r <= 32'd0;
    end else if (clear_pulse_s) begin
      word_cnt_r <= 32'd0; bit_cnt_r <= 32'd0;
    end else if (count_en_s) begin
      word_cnt_r <= (&word_cnt_r) ? word_cnt_r : word_cnt_r + 32'd1;
      bit_cnt_r  <= bit_sum_s[32] ? 32'hFFFF_FFFF : bit_sum_s[31:0];
    end
  end

  // Snapshot registers follow the counters while start is asserted
  always_ff @(posedge clk_i or negedge ARST_N) begin
    if (!ARST_N) begin
      word_snap_r <= 32'd0; bit_snap_r <= 32'd0;
    end else if (start_sync_r) begin
      word_snap_r <= word_cnt_r; bit_snap_r <= bit_cnt_r;
    end
  end

endmodule

// File: tb/tb_xcvr_pattern_checker.sv
// Directed testbench for xcvr_pattern_checker with hand-computed expectations.
module tb_xcvr_pattern_checker;

  logic        clk_i = 1'b0;
  logic        ARST_N;
  logic        rx_val_i;
  logic [31:0] data_in_i;
  logic [3:0]  rx_k_i, disp_err_i, lcv_err_i;
  logic        rx_ready_i, reset_en_i, mode_i, start_i, clear_i;
  logic        lane_arst_n_o, lock_o, error_o;
  logic [31:0] word_err_cnt_o, bit_err_cnt_o;
  logic [2:0]  state_o;

  int checks   = 0;
  int failures = 0;

  xcvr_pattern_checker dut (
    .clk_i(clk_i), .ARST_N(ARST_N), .rx_val_i(rx_val_i), .data_in_i(data_in_i),
    .rx_k_i(rx_k_i), .disp_err_i(disp_err_i), .lcv_err_i(lcv_err_i),
    .rx_ready_i(rx_ready_i), .reset_en_i(reset_en_i), .mode_i(mode_i),
    .start_i(start_i), .clear_i(clear_i), .lane_arst_n_o(lane_arst_n_o),
    .lock_o(lock_o), .error_o(error_o), .word_err_cnt_o(word_err_cnt_o),
    .bit_err_cnt_o(bit_err_cnt_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic do_reset();
    ARST_N = 1'b0; rx_val_i = 1'b0; data_in_i = 32'd0; rx_k_i = 4'd0;
    disp_err_i = 4'd0; lcv_err_i = 4'd0; rx_ready_i = 1'b1; reset_en_i = 1'b1;
    mode_i = 1'b0; start_i = 1'b0; clear_i = 1'b0;
    repeat (2) @(negedge clk_i);
    ARST_N = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] k);
    rx_val_i = 1'b1; data_in_i = d; rx_k_i = k;
    @(posedge clk_i);
    @(negedge clk_i);
    rx_val_i = 1'b0;
  endtask

  task automatic lock_seq(input logic [31:0] seed, input logic mode);
    mode_i = mode;
    repeat (4) send_word(32'h0000_00BC, 4'b0001);
    send_word(seed, 4'b0000);
  endtask

  task automatic take_snapshot();
    start_i = 1'b1;
    repeat (4) @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_reset();
    ARST_N = 1'b0; rx_val_i = 1'b0; data_in_i = 32'd0; rx_k_i = 4'd0;
    disp_err_i = 4'd0; lcv_err_i = 4'd0; rx_ready_i = 1'b1; reset_en_i = 1'b1;
    mode_i = 1'b0; start_i = 1'b0; clear_i = 1'b0;
    #12;
    checks++;
    if ({state_o, lock_o, error_o, lane_arst_n_o} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL reset_outputs got st=%0d lock=%b err=%b lane=%b want 0 0 0 1",
                           state_o, lock_o, error_o, lane_arst_n_o);
    end
    checks++;
    if ({word_err_cnt_o, bit_err_cnt_o} !== 64'd0) begin
      failures++; $display("FAIL reset_snap got %0d/%0d want 0/0", word_err_cnt_o, bit_err_cnt_o);
    end
    @(negedge clk_i);
    ARST_N = 1'b1;
    @(negedge clk_i);
    // Reset striking mid-lock while a bad word is on the bus
    lock_seq(32'h0000_0040, 1'b0);
    rx_val_i = 1'b1; data_in_i = 32'h0000_0000; rx_k_i = 4'd0;
    #2 ARST_N = 1'b0;
    @(posedge clk_i);
    #1;
    checks++;
    if ({state_o, lock_o, error_o} !== {3'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL midlock_reset got st=%0d lock=%b err=%b want 0 0 0", state_o, lock_o, error_o);
    end
    rx_val_i = 1'b0;
    @(negedge clk_i);
    ARST_N = 1'b1;
    @(negedge clk_i);
    take_snapshot();
    checks++;
    if (word_err_cnt_o !== 32'd0) begin
      failures++; $display("FAIL midlock_count got %0d want 0", word_err_cnt_o);
    end
  endtask

  task automatic test_lock();
    do_reset();
    send_word(32'h0000_00BC, 4'b0001);
    checks++;
    if (state_o !== 3'd1) begin failures++; $display("FAIL lock_sync_state got %0d want 1", state_o); end
    repeat (3) send_word(32'h0000_00BC, 4'b0001);
    checks++;
    if (state_o !== 3'd2) begin failures++; $display("FAIL lock_seed_state got %0d want 2", state_o); end
    send_word(32'h0000_0010, 4'b0000);
    checks++;
    if ({state_o, lock_o, error_o} !== {3'd3, 1'b1, 1'b0}) begin
      failures++; $display("FAIL lock_after_seed got st=%0d lock=%b err=%b want 3 1 0", state_o, lock_o, error_o);
    end
    send_word(32'h0000_0011, 4'b0000);
    checks++;
    if (error_o !== 1'b0) begin failures++; $display("FAIL lock_word11 got err=%b want 0", error_o); end
    send_word(32'h0000_0012, 4'b0000);
    checks++;
    if ({lock_o, error_o} !== 2'b10) begin
      failures++; $display("FAIL lock_word12 got lock=%b err=%b want 1 0", lock_o, error_o);
    end
  endtask

  task automatic test_single_error();
    send_word(32'h0000_0014, 4'b0000);
    checks++;
    if ({lock_o, error_o} !== 2'b11) begin
      failures++; $display("FAIL single_err_pulse got lock=%b err=%b want 1 1", lock_o, error_o);
    end
    send_word(32'h0000_0014, 4'b0000);
    checks++;
    if ({lock_o, error_o} !== 2'b10) begin
      failures++; $display("FAIL single_err_end got lock=%b err=%b want 1 0", lock_o, error_o);
    end
    take_snapshot();
    checks++;
    if ({word_err_cnt_o, bit_err_cnt_o} !== {32'd1, 32'd3}) begin
      failures++; $display("FAIL single_err_counts got %0d/%0d want 1/3", word_err_cnt_o, bit_err_cnt_o);
    end
  endtask

  task automatic test_loss();
    do_reset();
    lock_seq(32'h0000_0100, 1'b0);
    repeat (7) send_word(32'h0000_0000, 4'b0000);
    checks++;
    if ({state_o, lock_o} !== {3'd3, 1'b1}) begin
      failures++; $display("FAIL loss_after7 got st=%0d lock=%b want 3 1", state_o, lock_o);
    end
    send_word(32'h0000_0000, 4'b0000);
    checks++;
    if ({state_o, lock_o, error_o} !== {3'd0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL loss_after8 got st=%0d lock=%b err=%b want 0 0 1", state_o, lock_o, error_o);
    end
    take_snapshot();
    checks++;
    if ({word_err_cnt_o, bit_err_cnt_o} !== {32'd8, 32'd21}) begin
      failures++; $display("FAIL loss_counts got %0d/%0d want 8/21", word_err_cnt_o, bit_err_cnt_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    lock_seq(32'hFFFF_FFFE, 1'b0);
    send_word(32'hFFFF_FFFF, 4'b0000);
    checks++;
    if ({lock_o, error_o} !== 2'b10) begin failures++; $display("FAIL wrap_inc_ff got err=%b", error_o); end
    send_word(32'h0000_0000, 4'b0000);
    checks++;
    if ({lock_o, error_o} !== 2'b10) begin failures++; $display("FAIL wrap_inc_00 got err=%b", error_o); end
    do_reset();
    lock_seq(32'h0000_0001, 1'b1);
    mode_i = 1'b0;
    send_word(32'h0000_0000, 4'b0000);
    checks++;
    if ({lock_o, error_o} !== 2'b10) begin failures++; $display("FAIL wrap_dec_00 got err=%b", error_o); end
    send_word(32'hFFFF_FFFF, 4'b0000);
    checks++;
    if ({lock_o, error_o} !== 2'b10) begin failures++; $display("FAIL wrap_dec_ff got err=%b", error_o); end
    take_snapshot();
    checks++;
    if (word_err_cnt_o !== 32'd0) begin
      failures++; $display("FAIL wrap_counts got %0d want 0", word_err_cnt_o);
    end
  endtask

  task automatic test_pcs_reset();
    int low_cnt;
    do_reset();
    lock_seq(32'h0000_0100, 1'b0);
    checks++;
    if (lock_o !== 1'b1) begin failures++; $display("FAIL pcs_prelock got %b want 1", lock_o); end
    disp_err_i = 4'b0001;
    repeat (2) @(negedge clk_i);
    disp_err_i = 4'b0000; lcv_err_i = 4'b0010;
    repeat (2) @(negedge clk_i);
    lcv_err_i = 4'b0000;
    checks++;
    if (lane_arst_n_o !== 1'b1) begin failures++; $display("FAIL pcs_early_pulse got %b want 1", lane_arst_n_o); end
    low_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (lane_arst_n_o === 1'b0) low_cnt++;
      if (i == 0) begin
        checks++;
        if (lane_arst_n_o !== 1'b0) begin failures++; $display("FAIL pcs_pulse_start got %b want 0", lane_arst_n_o); end
      end
    end
    checks++;
    if (low_cnt != 4) begin failures++; $display("FAIL pcs_pulse_len got %0d want 4", low_cnt); end
    checks++;
    if ({state_o, lock_o} !== {3'd0, 1'b0}) begin
      failures++; $display("FAIL pcs_force_hunt got st=%0d lock=%b want 0 0", state_o, lock_o);
    end
    reset_en_i = 1'b0;
    disp_err_i = 4'b1000;
    repeat (6) @(negedge clk_i);
    disp_err_i = 4'b0000;
    low_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (lane_arst_n_o === 1'b0) low_cnt++;
    end
    checks++;
    if (low_cnt != 0) begin failures++; $display("FAIL pcs_disabled got %0d low cycles want 0", low_cnt); end
  endtask

  task automatic test_clear_snapshot();
    do_reset();
    lock_seq(32'h0000_0020, 1'b0);
    send_word(32'h0000_0021, 4'b0000);
    clear_i = 1'b1;
    send_word(32'h0000_0000, 4'b0000);
    clear_i = 1'b0;
    send_word(32'h0000_0023, 4'b0000);
    send_word(32'h0000_00FF, 4'b0000);
    checks++;
    if (error_o !== 1'b1) begin failures++; $display("FAIL clear_late_err got %b want 1", error_o); end
    take_snapshot();
    checks++;
    if ({word_err_cnt_o, bit_err_cnt_o} !== 64'd0) begin
      failures++; $display("FAIL clear_counts got %0d/%0d want 0/0", word_err_cnt_o, bit_err_cnt_o);
    end
    start_i = 1'b1;
    repeat (3) @(negedge clk_i);
    send_word(32'h0000_0024, 4'b0000);
    repeat (2) @(negedge clk_i);
    checks++;
    if ({word_err_cnt_o, bit_err_cnt_o} !== {32'd1, 32'd1}) begin
      failures++; $display("FAIL snap_track got %0d/%0d want 1/1", word_err_cnt_o, bit_err_cnt_o);
    end
    start_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_loss();
    test_wrap();
    test_pcs_reset();
    test_clear_snapshot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
